// File: rtl/snake_tile_renderer_if.sv
// snake_tile_renderer_if: Avalon-MM slave bus carrying register and tile-map accesses.
interface snake_tile_renderer_if;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [11:0] address;
   logic [15:0] writedata;
   logic [15:0] readdata;
   modport master (output chipselect, write, read, address, writedata, input readdata);
   modport slave (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/snake_tile_renderer.sv
// snake_tile_renderer: tile-map sprite renderer with reset clear sequencer, transparency key and map readback.
// Define SNAKE_TILE_FLIP_EN to let entry bits [5:4] mirror the sprite horizontally/vertically.
module snake_tile_renderer #(
   parameter int          TILE_LOG2 = 4,
   parameter int          COLS      = 40,
   parameter int          ROWS      = 30,
   parameter int          SPR_LOG2  = 4,
   parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
   input  logic                            clk,
   input  logic                            reset,
   snake_tile_renderer_if.slave            bus,
   input  logic [10:0]                     hcount,
   input  logic [9:0]                      vcount,
   input  logic                            blank_n_in,
   input  logic                            hs_in,
   input  logic                            vs_in,
   output logic [SPR_LOG2+2*TILE_LOG2-1:0] spr_addr,
   input  logic [15:0]                     spr_data,
   output logic [7:0]                      VGA_R,
   output logic [7:0]                      VGA_G,
   output logic [7:0]                      VGA_B,
   output logic                            VGA_HS,
   output logic                            VGA_VS,
   output logic                            VGA_BLANK_n
);
   localparam int N  = COLS * ROWS;
   localparam int AW = $clog2(N);
   localparam int T  = TILE_LOG2;
   typedef enum logic {CLEAR, IDLE} state_t;

   state_t                  state_q, state_d;
   logic [AW-1:0]           clr_idx_q, clr_idx_d;
   logic [7:0]              bg_r_q, bg_r_d, bg_g_q, bg_g_d, bg_b_q, bg_b_d;
   logic                    en_q, en_d;
   logic                    rd_tile_q, rd_tile_d;
   logic [15:0]             reg_rd_q, reg_rd_d;
   logic [T-1:0]            col_q, col_d, row_q, row_d;
   logic                    out1_q, out1_d, bg2_q, bg2_d, bg3_q, bg3_d;
   logic [SPR_LOG2+2*T-1:0] spr_addr_q, spr_addr_d;
   logic [3:0]              blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
   logic [7:0]              r_q, r_d, g_q, g_d, b_q, b_d;

   logic [7:0]              tile_mem [N];
   logic [7:0]              map_rd_a, map_rd_b;
   logic [AW-1:0]           a_addr, b_addr;
   logic [7:0]              b_wdata;
   logic                    b_we, busy, wr, rd, is_tile, hflip, vflip, use_bg;
   logic [9-T:0]            tile_row, tile_col;
   logic [SPR_LOG2-1:0]     idx;
   logic                    unused_ok;

   always_comb begin
      busy = state_q == CLEAR;
      wr = bus.chipselect && bus.write;
      rd = bus.chipselect && bus.read;
      is_tile = bus.address < 12'(N);
      state_d = busy && clr_idx_q == AW'(N - 1) ? IDLE : state_q;
      clr_idx_d = busy ? clr_idx_q + AW'(1) : clr_idx_q;
      // The clear sequencer owns port B while busy, so Avalon tile writes are dropped then.
      b_we = busy || (wr && is_tile);
      b_addr = busy ? clr_idx_q : bus.address[AW-1:0];
      b_wdata = busy ? 8'h00 : bus.writedata[7:0];
      bg_r_d = wr && bus.address == 12'h800 ? bus.writedata[7:0] : bg_r_q;
      bg_g_d = wr && bus.address == 12'h801 ? bus.writedata[7:0] : bg_g_q;
      bg_b_d = wr && bus.address == 12'h802 ? bus.writedata[7:0] : bg_b_q;
      en_d = wr && bus.address == 12'h803 ? bus.writedata[0] : en_q;
      rd_tile_d = rd && is_tile;
      reg_rd_d = !rd || is_tile ? 16'h0000 :
                 bus.address == 12'h800 ? {8'h00, bg_r_q} :
                 bus.address == 12'h801 ? {8'h00, bg_g_q} :
                 bus.address == 12'h802 ? {8'h00, bg_b_q} :
                 bus.address == 12'h803 ? {14'b0, busy, en_q} : 16'h0000;
      tile_row = vcount[9:T];
      tile_col = hcount[10:T+1];
      out1_d = 32'(tile_row) >= ROWS || 32'(tile_col) >= COLS;
      a_addr = out1_d ? '0 : AW'(32'(tile_row) * COLS + 32'(tile_col));
      col_d = hcount[T:1];
      row_d = vcount[T-1:0];
      idx = map_rd_a[SPR_LOG2-1:0];
`ifdef SNAKE_TILE_FLIP_EN
      hflip = map_rd_a[4];
      vflip = map_rd_a[5];
`else
      hflip = 1'b0;
      vflip = 1'b0;
`endif
      spr_addr_d = {idx, row_q ^ {T{vflip}}, col_q ^ {T{hflip}}};
      bg2_d = out1_q || idx == '0;
      bg3_d = bg2_q;
      blank_d = {blank_q[2:0], blank_n_in};
      hs_d = {hs_q[2:0], hs_in};
      vs_d = {vs_q[2:0], vs_in};
      use_bg = !en_q || busy || bg3_q || spr_data == KEY_COLOR;
      r_d = !blank_q[2] ? 8'h00 : use_bg ? bg_r_q : {spr_data[15:11], 3'b000};
      g_d = !blank_q[2] ? 8'h00 : use_bg ? bg_g_q : {spr_data[10:5], 2'b00};
      b_d = !blank_q[2] ? 8'h00 : use_bg ? bg_b_q : {spr_data[4:0], 3'b000};
   end

   always_ff @(posedge clk) begin
      if (b_we) tile_mem[b_addr] <= b_wdata;
      map_rd_b <= tile_mem[b_addr];
      map_rd_a <= tile_mem[a_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR;
         clr_idx_q <= '0;
         bg_r_q <= 8'h00;
         bg_g_q <= 8'h80;
         bg_b_q <= 8'h80;
         en_q <= 1'b1;
         rd_tile_q <= 1'b0;
         reg_rd_q <= 16'h0000;
         col_q <= '0;
         row_q <= '0;
         out1_q <= 1'b0;
         bg2_q <= 1'b0;
         bg3_q <= 1'b0;
         spr_addr_q <= '0;
         blank_q <= 4'h0;
         hs_q <= 4'hF;
         vs_q <= 4'hF;
         r_q <= 8'h00;
         g_q <= 8'h00;
         b_q <= 8'h00;
      end else begin
         state_q <= state_d;
         clr_idx_q <= clr_idx_d;
         bg_r_q <= bg_r_d;
         bg_g_q <= bg_g_d;
         bg_b_q <= bg_b_d;
         en_q <= en_d;
         rd_tile_q <= rd_tile_d;
         reg_rd_q <= reg_rd_d;
         col_q <= col_d;
         row_q <= row_d;
         out1_q <= out1_d;
         bg2_q <= bg2_d;
         bg3_q <= bg3_d;
         spr_addr_q <= spr_addr_d;
         blank_q <= blank_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         r_q <= r_d;
         g_q <= g_d;
         b_q <= b_d;
      end
   end

   assign bus.readdata = rd_tile_q ? {8'h00, map_rd_b} : reg_rd_q;
   assign spr_addr = spr_addr_q;
   assign VGA_R = r_q;
   assign VGA_G = g_q;
   assign VGA_B = b_q;
   assign VGA_HS = hs_q[3];
   assign VGA_VS = vs_q[3];
   assign VGA_BLANK_n = blank_q[3];
   assign unused_ok = ^{hcount[0], map_rd_a[7:SPR_LOG2], bus.writedata[15:8]};
endmodule

// File: tb/tb_snake_tile_renderer.sv
// tb_snake_tile_renderer: randomized scoreboard bench for snake_tile_renderer against a tile-map reference model.
module tb_snake_tile_renderer;
   localparam int COLS = 40;
   localparam int ROWS = 30;
   localparam int N = COLS * ROWS;
   localparam logic [15:0] KEY = 16'hF81F;
   typedef struct packed {logic [7:0] r, g, b; logic hs, vs, bl;} pix_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] hcount = '0;
   logic [9:0]  vcount = '0;
   logic        blank_n_in = 1'b1, hs_in = 1'b0, vs_in = 1'b0;
   logic [11:0] spr_addr;
   logic [15:0] spr_data = '0;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS, VGA_VS, VGA_BLANK_n;

   snake_tile_renderer_if bus();

   snake_tile_renderer dut (
      .clk(clk), .reset(reset), .bus(bus), .hcount(hcount), .vcount(vcount),
      .blank_n_in(blank_n_in), .hs_in(hs_in), .vs_in(vs_in), .spr_addr(spr_addr), .spr_data(spr_data),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n)
   );

   always #5 clk = ~clk;

   int          mdl [N];
   int          bg_r, bg_g, bg_b;
   bit          en;
   pix_t        pixq [$];
   logic [15:0] rdq [$];
   bit          pix_vld = 1'b0, rd_chk = 1'b0, rd_v = 1'b0;
   logic [3:0]  vld_sr = 4'h0;
   int          tests = 0, fails = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sprite ROM contents: sprite 3 solid red, sprite 7 fully transparent, the rest pseudo-random.
   function automatic logic [15:0] rom_f(int a);
      if (a / 256 == 7) return KEY;
      if (a / 256 == 3) return 16'hF800;
      return 16'(a * 40503 + 12345);
   endfunction

   function automatic pix_t model_pix(int hc, int vc, bit bl, bit hs, bit vs);
      pix_t p;
      int px, py, tc, tr, e, idx, cx, cy, d;
      bit outside;
      px = hc / 2;
      py = vc;
      tc = px / 16;
      tr = py / 16;
      outside = tc >= COLS || tr >= ROWS;
      e = outside ? 0 : mdl[tr * COLS + tc];
      idx = e % 16;
      cx = px % 16;
      cy = py % 16;
`ifdef SNAKE_TILE_FLIP_EN
      if ((e / 16) % 2 == 1) cx = 15 - cx;
      if ((e / 32) % 2 == 1) cy = 15 - cy;
`endif
      d = int'(rom_f(idx * 256 + cy * 16 + cx));
      p.hs = hs;
      p.vs = vs;
      p.bl = bl;
      if (!bl) begin
         p.r = 0; p.g = 0; p.b = 0;
      end else if (!en || outside || idx == 0 || d == int'(KEY)) begin
         p.r = 8'(bg_r); p.g = 8'(bg_g); p.b = 8'(bg_b);
      end else begin
         p.r = 8'((d / 2048) * 8);
         p.g = 8'(((d / 32) % 64) * 4);
         p.b = 8'((d % 32) * 8);
      end
      return p;
   endfunction

   function automatic logic [15:0] model_rd(int a);
      if (a < N) return 16'(mdl[a]);
      if (a == 'h800) return 16'(bg_r);
      if (a == 'h801) return 16'(bg_g);
      if (a == 'h802) return 16'(bg_b);
      if (a == 'h803) return {15'b0, en};
      return 16'h0000;
   endfunction

   function automatic void model_wr(int a, int d);
      if (a < N) mdl[a] = d & 255;
      else if (a == 'h800) bg_r = d & 255;
      else if (a == 'h801) bg_g = d & 255;
      else if (a == 'h802) bg_b = d & 255;
      else if (a == 'h803) en = (d & 1) == 1;
   endfunction

   function automatic void model_reset();
      foreach (mdl[i]) mdl[i] = 0;
      bg_r = 'h00; bg_g = 'h80; bg_b = 'h80;
      en = 1'b1;
   endfunction

   always @(posedge clk) spr_data <= rom_f(int'(spr_addr));

   always @(posedge clk) begin
      vld_sr <= {vld_sr[2:0], pix_vld};
      rd_v <= rd_chk;
   end

   always @(negedge clk) begin : monitor
      pix_t e;
      logic [15:0] r;
      if (vld_sr[3]) begin
         if (pixq.size() == 0) begin
            tests++; fails++;
            $display("FAIL pix: got an output with an empty expected queue");
         end else begin
            e = pixq.pop_front();
            chk("pix", 32'({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n}), 32'(e));
         end
      end
      if (rd_v) begin
         if (rdq.size() == 0) begin
            tests++; fails++;
            $display("FAIL readdata: got a read with an empty expected queue");
         end else begin
            r = rdq.pop_front();
            chk("readdata", 32'(bus.readdata), 32'(r));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(int hc, int vc, bit bl, bit hs, bit vs);
      hcount = 11'(hc); vcount = 10'(vc);
      blank_n_in = bl; hs_in = hs; vs_in = vs;
      pix_vld = 1'b1;
      pixq.push_back(model_pix(hc, vc, bl, hs, vs));
      step();
      pix_vld = 1'b0;
   endtask

   task automatic drain();
      repeat (6) step();
   endtask

   task automatic avs(int a, int d, bit w, bit r);
      if (r) begin
         rdq.push_back(model_rd(a));
         rd_chk = 1'b1;
      end
      if (w) model_wr(a, d);
      bus.chipselect = 1'b1; bus.write = w; bus.read = r;
      bus.address = 12'(a); bus.writedata = 16'(d);
      step();
      bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
      rd_chk = 1'b0;
   endtask

   task automatic stream(int n);
      for (int i = 0; i < n; i++)
         pix(int'($urandom_range(0, 1399)), int'($urandom_range(0, 524)), 1'($urandom_range(0, 7) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain();
   endtask

   // Polls ctrl until busy drops; with inject, cycles 300/301 write tile 7 and bg_r instead of polling.
   task automatic wait_clear(bit inject, output int n, output logic [15:0] last);
      bit done, ctrl;
      done = 1'b0;
      n = 0;
      last = '0;
      for (int c = 0; c < 2000 && !done; c++) begin
         ctrl = !(inject && (c == 300 || c == 301));
         bus.chipselect = 1'b1; bus.read = ctrl; bus.write = !ctrl;
         bus.address = ctrl ? 12'h803 : (c == 300 ? 12'd7 : 12'h800);
         bus.writedata = c == 300 ? 16'h0066 : 16'h0011;
         step();
         last = bus.readdata;
         if (!ctrl || bus.readdata[1]) n++;
         else done = 1'b1;
      end
      bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
   endtask

   initial begin
      int n;
      logic [15:0] last;
      bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
      bus.address = '0; bus.writedata = '0;
      model_reset();
      repeat (5) step();
      chk("rst_readdata", 32'(bus.readdata), 32'h0);
      chk("rst_spr_addr", 32'(spr_addr), 32'h0);
      chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
      chk("rst_hs_vs", 32'({VGA_HS, VGA_VS}), 32'h3);
      chk("rst_blank", 32'(VGA_BLANK_n), 32'h0);
      reset = 1'b0;
      wait_clear(1'b0, n, last);
      chk("busy_cycles", 32'(n), 32'd1200);
      chk("ctrl_idle", 32'(last), 32'h1);
      foreach (mdl[i]) mdl[i] = 0;
      for (int a = 0; a < 8; a++) avs(a == 0 ? 5 : a == 5 ? 'h900 : a == 6 ? N : a == 7 ? 'hFFF : 'h7FF + a, 0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) pix(int'($urandom_range(0, 1279)), int'($urandom_range(0, 479)), 1'b1, 1'b1, 1'b1);
      drain();
      avs(410, 3, 1'b1, 1'b0);
      pix(330, 170, 1'b1, 1'b1, 1'b0);
      pix(330, 170, 1'b1, 1'b0, 1'b1);
      chk("spr_addr", 32'(spr_addr), 32'h3A5);
      pix(330, 170, 1'b0, 1'b1, 1'b1);
      drain();
      avs(410, 7, 1'b1, 1'b0);
      pix(330, 170, 1'b1, 1'b1, 1'b1);
      drain();
      avs(410, 0, 1'b1, 1'b0);
      pix(330, 170, 1'b1, 1'b1, 1'b1);
      drain();
      avs(410, 3, 1'b1, 1'b0);
      avs('h803, 0, 1'b1, 1'b0);
      pix(330, 170, 1'b1, 1'b1, 1'b1);
      drain();
      avs('h803, 1, 1'b1, 1'b1);
      avs(410, 'h13, 1'b1, 1'b0);
      pix(330, 170, 1'b1, 1'b1, 1'b1);
      pix(330, 170, 1'b1, 1'b1, 1'b1);
`ifdef SNAKE_TILE_FLIP_EN
      chk("spr_addr_flip", 32'(spr_addr), 32'h3AA);
`else
      chk("spr_addr_flip", 32'(spr_addr), 32'h3A5);
`endif
      drain();
      avs(7, 'h55, 1'b1, 1'b0);
      avs(7, 0, 1'b0, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (500) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      wait_clear(1'b1, n, last);
      chk("busy_restart", 32'(n), 32'd1200);
      model_reset();
      bg_r = 'h11;
      avs(7, 0, 1'b0, 1'b1);
      avs('h800, 0, 1'b0, 1'b1);
      avs('h803, 0, 1'b0, 1'b1);
      for (int i = 0; i < N; i++) avs(i, int'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) avs('h800 + i, int'($urandom_range(0, 255)), 1'b1, 1'b0);
      stream(2500);
      avs('h803, 0, 1'b1, 1'b0);
      stream(200);
      avs('h803, 1, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) avs(int'($urandom_range(0, N - 1)), 0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         n = int'($urandom_range(0, N - 1));
         avs(n, int'($urandom_range(0, 255)), 1'b1, 1'b1);
         avs(n, 0, 1'b0, 1'b1);
      end
      stream(300);
      chk("pix_queue_left", 32'(pixq.size()), 32'h0);
      chk("rd_queue_left", 32'(rdq.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete within the time limit");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/snake_tile_renderer.md
Name: snake_tile_renderer

Overview:
- Parametrised tile-map sprite renderer for the snake VGA peripheral. It replaces hard-coded per-sprite position compares.
- Software writes a COLS x ROWS tile map over the Avalon slave. Each entry selects one 2^TILE_LOG2-square RGB565 sprite from an external sync-read sprite ROM.
- A fixed-latency pipeline converts counter coordinates (from vga_counters) into registered RGB. Sync and blank are delay-matched to the RGB.
- Adds features the previous block lacks: a reset clear sequencer, transparency keying, and tile-map readback.

Parameters:
- TILE_LOG2, 4, log2 of tile edge in pixels (16x16).
- COLS, 40, tile columns (640 >> TILE_LOG2).
- ROWS, 30, tile rows (480 >> TILE_LOG2).
- SPR_LOG2, 4, log2 of sprite count in the ROM (16 sprites).
- KEY_COLOR, 16'hF81F, RGB565 value treated as transparent.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- chipselect  in  1  Avalon select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  12  word address.
- writedata  in  16  write data.
- readdata  out  16  read data, valid 1 clk after read.
- hcount  in  11  from vga_counters; hcount[10:1] is the pixel column.
- vcount  in  10  pixel row.
- blank_n_in, hs_in, vs_in  in  1 each  raw timing from vga_counters.
- spr_addr  out  SPR_LOG2+2*TILE_LOG2  sprite ROM address, registered.
- spr_data  in  16  RGB565 from ROM, valid 1 clk after spr_addr.
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour.
- VGA_HS, VGA_VS, VGA_BLANK_n  out  1 each  delay-matched timing.

Behaviour:
- Address map:
  - 0..COLS*ROWS-1: tile map, entry = row*COLS + col, 8 bits stored.
  - 0x800 / 0x801 / 0x802: bg_r / bg_g / bg_b.
  - 0x803: ctrl. Bit0 = enable (R/W). Bit1 = busy (RO).
  - Unmapped addresses: writes ignored, reads return 0.
- Entry format: [SPR_LOG2-1:0] sprite index, [5:4] flip, [7:6] stored but ignored. Sprite index 0 means empty tile (background).
- Reset values:
  - bg = 00/80/80, enable = 1, readdata = 0, spr_addr = 0.
  - RGB = 0, VGA_HS = VGA_VS = 1, VGA_BLANK_n = 0.
  - Sequencer enters CLEAR.
- Sequencer states:
  - CLEAR: writes 0 to entries 0..COLS*ROWS-1, one per clk. Busy = 1. Avalon tile writes are dropped; register writes are accepted.
  - IDLE: entered after the last entry is cleared. Busy = 0.
  - Reset asserted in any state restarts CLEAR at entry 0.
- Render pipeline, 4 clk from hcount/vcount to RGB:
  - S0: register px = hcount[10:1], py = vcount. Tile map address = (py>>TILE_LOG2)*COLS + (px>>TILE_LOG2).
  - S1: tile map read data available.
  - S2: spr_addr = {index, py[TILE_LOG2-1:0], px[TILE_LOG2-1:0]}.
  - S3: spr_data sampled.
  - S4: RGB registered.
- blank_n_in, hs_in and vs_in pass through an identical 4-stage delay.
- Colour select at S4:
  - Delayed blank_n = 0: RGB = 0.
  - Else if enable = 0, busy = 1, index = 0, tile outside the COLS x ROWS map, or spr_data == KEY_COLOR: RGB = bg.
  - Else RGB565 expands as R = {d[15:11], 3'b0}, G = {d[10:5], 2'b0}, B = {d[4:0], 3'b0}.
- Tile map is true dual-port: port A is render read, port B is Avalon R/W. A read-during-write to the same entry returns old data; a new value is visible to render from the next clk.
- Read and write both asserted in one cycle: the write wins and readdata returns the pre-write value.

Optional Feature:
- SNAKE_TILE_FLIP_EN defined: entry bit4 = hflip and bit5 = vflip. The in-tile column is px[TILE_LOG2-1:0] inverted when hflip; the row is inverted the same way when vflip. One head sprite can then serve all four directions. Latency is unchanged.
- Undefined: bits [5:4] are stored and read back but have no effect on rendering.

Test Plan:
- Reset, then hold for 1200 clk -> busy = 1 for exactly 1200 clk. Reading tile 5 afterwards returns 0. Screen is bg 00/80/80.
- Write tile 410 (row 10, col 10) = 3, then render px = 165, py = 170 -> spr_addr = {3, 4'd10, 4'd5}. ROM returns 16'hF800, so 4 clk later RGB = F8/00/00.
- Same tile with ROM returning KEY_COLOR -> RGB = bg. Writing index 0 -> RGB = bg.
- Write during CLEAR, then read after busy falls -> entry reads 0. Write during IDLE -> readback equals the value written.
- Enable = 0 with a non-empty tile -> RGB = bg. hs_in pulse -> VGA_HS pulse delayed exactly 4 clk; BLANK_n likewise.
- With SNAKE_TILE_FLIP_EN, entry = 0x13 at px = 165, py = 170 -> spr_addr = {3, 4'd10, 4'd10}.
